// File: rtl/alu_pkg.sv
// Shared definitions for the word-serial ALU: op codes, FSM state encoding
// and the radix-4 Booth partial-product select codes.
package alu_pkg;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   // LD_A has no dwell cycle: the first operand is captured on the BEGIN edge.
   typedef enum logic [3:0] {
      ST_IDLE,
      ST_LD_A,
      ST_LD_Q,
      ST_LD_M,
      ST_CHK,
      ST_ADDSUB,
      ST_BOOTH,
      ST_DIV_IT,
      ST_DIV_FIX,
      ST_OUT_HI,
      ST_OUT_LO
   } state_t;

   typedef enum logic [2:0] {
      BS_ZERO,
      BS_PM,
      BS_P2M,
      BS_MM,
      BS_M2M
   } booth_sel_t;

   function automatic booth_sel_t booth_decode(input logic [2:0] bits);
      booth_sel_t sel;
      case (bits)
         3'b001, 3'b010: sel = BS_PM;
         3'b011:         sel = BS_P2M;
         3'b100:         sel = BS_M2M;
         3'b101, 3'b110: sel = BS_MM;
         default:        sel = BS_ZERO;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/adder_rca.sv
// Plain ripple-carry adder; the ALU shares one instance across all of its
// add, subtract, compare, Booth and divide steps.
module adder_rca #(
   parameter int N = 10
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         cin,
   output logic [N-1:0] sum
);

   logic [N:0] carry;

   assign carry[0] = cin;

   generate
      for (genvar gi = 0; gi < N; gi++) begin : g_fa
         assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
         assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
      end
   endgenerate

endmodule

// File: rtl/alu_param_seq.sv
// Multi-cycle WIDTH-bit ALU (add/sub, radix-4 Booth multiply, non-restoring
// divide) using the BEGIN/inbus/outbus/END word-serial protocol.
module alu_param_seq
   import alu_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             BEGIN,
   input  logic [1:0]       op_code,
   input  logic [WIDTH-1:0] inbus,
   output logic [WIDTH-1:0] outbus,
   output logic             out_valid,
   output logic             END,
   output logic             busy,
   output logic             err
);

   localparam int AW    = WIDTH + 2;
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] BOOTH_LAST = CNT_W'(WIDTH / 2 - 1);
   localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(WIDTH - 1);

   state_t           state_reg;
   logic [1:0]       op_reg;
   logic [AW-1:0]    a_reg;
   logic [WIDTH-1:0] q_reg;
   logic             qm1_reg;
   logic [WIDTH-1:0] m_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [WIDTH-1:0] out_reg;
   logic             valid_reg;
   logic             end_reg;
   logic             busy_reg;
   logic             err_reg;
   logic             err_pend_reg;

   logic [AW-1:0]    m_sext;
   logic [AW-1:0]    m_zext;
   logic [AW-1:0]    m2_sext;
   logic [AW-1:0]    a_dsh;
   logic [AW-1:0]    add_a;
   logic [AW-1:0]    add_b;
   logic             add_cin;
   logic [AW-1:0]    add_sum;
   booth_sel_t       bsel;
   logic             is_sub;
   logic             ovf;
   logic             quot_ovf;
   logic [AW-1:0]    a_bsh;
   logic [WIDTH-1:0] q_bsh;

   assign m_sext  = {{2{m_reg[WIDTH-1]}}, m_reg};
   assign m_zext  = {2'b00, m_reg};
   assign m2_sext = {m_sext[AW-2:0], 1'b0};
   assign a_dsh   = {a_reg[AW-2:0], q_reg[WIDTH-1]};
   assign bsel    = booth_decode({q_reg[1:0], qm1_reg});
   assign is_sub  = (op_reg == OP_SUB);

   // Operand steering for the single shared adder, one use per state.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_cin = 1'b0;
      case (state_reg)
         ST_ADDSUB: begin
            add_a   = {{2{a_reg[WIDTH-1]}}, a_reg[WIDTH-1:0]};
            add_b   = is_sub ? ~m_sext : m_sext;
            add_cin = is_sub;
         end
         ST_CHK: begin
            add_a   = {2'b00, a_reg[WIDTH-1:0]};
            add_b   = ~m_zext;
            add_cin = 1'b1;
         end
         ST_BOOTH: begin
            add_a = a_reg;
            case (bsel)
               BS_PM:   add_b = m_sext;
               BS_P2M:  add_b = m2_sext;
               BS_MM: begin
                  add_b   = ~m_sext;
                  add_cin = 1'b1;
               end
               BS_M2M: begin
                  add_b   = ~m2_sext;
                  add_cin = 1'b1;
               end
               default: add_b = '0;
            endcase
         end
         ST_DIV_IT: begin
            add_a = a_dsh;
            if (a_reg[AW-1]) begin
               add_b = m_zext;
            end else begin
               add_b   = ~m_zext;
               add_cin = 1'b1;
            end
         end
         ST_DIV_FIX: begin
            add_a = a_reg;
            add_b = a_reg[AW-1] ? m_zext : '0;
         end
         default: begin
            add_a   = '0;
            add_b   = '0;
            add_cin = 1'b0;
         end
      endcase
   end

   adder_rca #(.N(AW)) u_adder (
      .a   (add_a),
      .b   (add_b),
      .cin (add_cin),
      .sum (add_sum)
   );

   // Overflow when both effective operands share a sign the result lacks.
   assign ovf      = (a_reg[WIDTH-1] == (m_reg[WIDTH-1] ^ is_sub)) &&
                     (add_sum[WIDTH-1] != a_reg[WIDTH-1]);
   assign quot_ovf = (m_reg == '0) || !add_sum[AW-1];
   assign a_bsh    = {{2{add_sum[AW-1]}}, add_sum[AW-1:2]};
   assign q_bsh    = {add_sum[1:0], q_reg[WIDTH-1:2]};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg    <= ST_IDLE;
         op_reg       <= '0;
         a_reg        <= '0;
         q_reg        <= '0;
         qm1_reg      <= 1'b0;
         m_reg        <= '0;
         cnt_reg      <= '0;
         out_reg      <= '0;
         valid_reg    <= 1'b0;
         end_reg      <= 1'b0;
         busy_reg     <= 1'b0;
         err_reg      <= 1'b0;
         err_pend_reg <= 1'b0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (BEGIN) begin
                  op_reg       <= op_code;
                  a_reg        <= {2'b00, inbus};
                  err_reg      <= 1'b0;
                  err_pend_reg <= 1'b0;
                  busy_reg     <= 1'b1;
                  state_reg    <= (op_code == OP_DIV) ? ST_LD_Q : ST_LD_M;
               end
            end
            ST_LD_Q: begin
               q_reg     <= inbus;
               state_reg <= ST_LD_M;
            end
            ST_LD_M: begin
               m_reg <= inbus;
               if (op_reg == OP_DIV) begin
                  state_reg <= ST_CHK;
               end else if (op_reg == OP_MUL) begin
                  q_reg     <= a_reg[WIDTH-1:0];
                  a_reg     <= '0;
                  qm1_reg   <= 1'b0;
                  cnt_reg   <= '0;
                  state_reg <= ST_BOOTH;
               end else begin
                  state_reg <= ST_ADDSUB;
               end
            end
            ST_ADDSUB: begin
               a_reg     <= add_sum;
               out_reg   <= add_sum[WIDTH-1:0];
               valid_reg <= 1'b1;
               end_reg   <= 1'b1;
               err_reg   <= ovf;
               state_reg <= ST_OUT_LO;
            end
            ST_CHK: begin
               if (quot_ovf) begin
                  err_pend_reg <= 1'b1;
                  a_reg        <= '0;
                  q_reg        <= '0;
                  out_reg      <= '0;
                  valid_reg    <= 1'b1;
                  state_reg    <= ST_OUT_HI;
               end else begin
                  cnt_reg   <= '0;
                  state_reg <= ST_DIV_IT;
               end
            end
            ST_BOOTH: begin
               a_reg   <= a_bsh;
               q_reg   <= q_bsh;
               qm1_reg <= q_reg[1];
               if (cnt_reg == BOOTH_LAST) begin
                  out_reg   <= a_bsh[WIDTH-1:0];
                  valid_reg <= 1'b1;
                  state_reg <= ST_OUT_HI;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_DIV_IT: begin
               a_reg <= add_sum;
               q_reg <= {q_reg[WIDTH-2:0], ~add_sum[AW-1]};
               if (cnt_reg == DIV_LAST) begin
                  state_reg <= ST_DIV_FIX;
               end else begin
                  cnt_reg <= cnt_reg + CNT_W'(1);
               end
            end
            ST_DIV_FIX: begin
               a_reg     <= add_sum;
               out_reg   <= q_reg;
               valid_reg <= 1'b1;
               state_reg <= ST_OUT_HI;
            end
            ST_OUT_HI: begin
               out_reg   <= (op_reg == OP_DIV) ? a_reg[WIDTH-1:0] : q_reg;
               end_reg   <= 1'b1;
               err_reg   <= err_pend_reg;
               state_reg <= ST_OUT_LO;
            end
            ST_OUT_LO: begin
               out_reg   <= '0;
               valid_reg <= 1'b0;
               end_reg   <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
            default: begin
               out_reg   <= '0;
               valid_reg <= 1'b0;
               end_reg   <= 1'b0;
               busy_reg  <= 1'b0;
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign outbus    = out_reg;
   assign out_valid = valid_reg;
   assign END       = end_reg;
   assign busy      = busy_reg;
   assign err       = err_reg;

endmodule

// File: tb/tb_alu_param_seq.sv
// Directed and randomised checks of the word-serial ALU at WIDTH 8 and 16.
module tb_alu_param_seq;
   import alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset;
   logic        beg8, beg16;
   logic [1:0]  op_code;
   logic [15:0] inbus;

   logic [7:0]  outbus8;
   logic        valid8, end8, busy8, err8;
   logic [15:0] outbus16;
   logic        valid16, end16, busy16, err16;

   int total = 0;
   int bad   = 0;

   logic [15:0] r_hi, r_lo;
   logic        r_err;
   int          r_endc, r_nval;
   logic        r_leak;

   always #5 clk = ~clk;

   alu_param_seq #(.WIDTH(8)) dut8 (
      .clk(clk), .reset(reset), .BEGIN(beg8), .op_code(op_code), .inbus(inbus[7:0]),
      .outbus(outbus8), .out_valid(valid8), .END(end8), .busy(busy8), .err(err8)
   );

   alu_param_seq #(.WIDTH(16)) dut16 (
      .clk(clk), .reset(reset), .BEGIN(beg16), .op_code(op_code), .inbus(inbus),
      .outbus(outbus16), .out_valid(valid16), .END(end16), .busy(busy16), .err(err16)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_begin(input bit w16, input logic v);
      if (w16) beg16 = v;
      else     beg8  = v;
   endtask

   // Start one operation in the cycle after the current one and follow it to END.
   task automatic run(input bit w16, input logic [1:0] op, input logic [15:0] w0,
                      input logic [15:0] w1, input logic [15:0] w2, input int poke);
      logic [15:0] o;
      logic        v, e;
      @(posedge clk); #1;
      op_code = op;
      inbus   = w0;
      set_begin(w16, 1'b1);
      @(posedge clk); #1;
      r_hi = '0; r_lo = '0; r_err = 1'b0; r_endc = -1; r_nval = 0; r_leak = 1'b0;
      for (int cyc = 1; cyc < 64 && r_endc < 0; cyc++) begin
         op_code = ~op;
         if (cyc == 1)      inbus = w1;
         else if (cyc == 2) inbus = w2;
         else               inbus = 16'($urandom);
         set_begin(w16, cyc == poke);
         o = w16 ? outbus16 : {8'h00, outbus8};
         v = w16 ? valid16 : valid8;
         e = w16 ? end16 : end8;
         if (v) begin
            r_nval++;
            if (r_nval == 1) r_hi = o;
            if (e) begin
               r_lo   = o;
               r_err  = w16 ? err16 : err8;
               r_endc = cyc;
            end
         end else if (o != '0) begin
            r_leak = 1'b1;
         end
         if (r_endc < 0) begin
            @(posedge clk); #1;
         end
      end
      set_begin(w16, 1'b0);
      $display("txn w%0d op=%0d %h/%h/%h -> hi=%h lo=%h err=%0d end@c%0d", w16 ? 16 : 8,
               op, w0, w1, w2, r_hi, r_lo, r_err, r_endc);
   endtask

   task automatic check_run(input string tag, input logic [15:0] hi, input logic [15:0] lo,
                            input logic e, input int endc, input int nval);
      chk({tag, "_hi"}, 32'(r_hi), 32'(hi));
      chk({tag, "_lo"}, 32'(r_lo), 32'(lo));
      chk({tag, "_err"}, 32'(r_err), 32'(e));
      chk({tag, "_endc"}, r_endc, endc);
      chk({tag, "_nval"}, r_nval, nval);
      chk({tag, "_zero_idle"}, 32'(r_leak), 32'd0);
   endtask

   initial begin
      logic [15:0] a, b, m, dh, dl;
      logic [31:0] dvd, prod;
      int          pa, pb;

      reset = 1'b0; beg8 = 1'b0; beg16 = 1'b0; op_code = 2'b00; inbus = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst8_outputs", {20'h0, valid8, end8, busy8, err8, outbus8}, 32'h0);
      chk("rst16_outputs", {12'h0, valid16, end16, busy16, err16, outbus16}, 32'h0);
      reset = 1'b1;

      run(0, OP_ADD, 16'h7F, 16'h01, 16'h00, 0);
      check_run("add_7f_01", 16'h80, 16'h80, 1'b1, 3, 1);
      repeat (3) @(posedge clk);
      #1;
      chk("err_hold", {30'h0, err8, busy8}, 32'h2);

      run(0, OP_SUB, 16'h05, 16'h07, 16'h00, 0);
      check_run("sub_05_07", 16'hFE, 16'hFE, 1'b0, 3, 1);

      run(0, OP_MUL, 16'hFD, 16'h05, 16'h00, 0);
      check_run("mul_fd_05", 16'hFF, 16'hF1, 1'b0, 7, 2);

      run(0, OP_MUL, 16'h80, 16'h80, 16'h00, 0);
      check_run("mul_80_80", 16'h40, 16'h00, 1'b0, 7, 2);

      run(0, OP_DIV, 16'h01, 16'h23, 16'h10, 0);
      check_run("div_0123_10", 16'h12, 16'h03, 1'b0, 14, 2);

      run(0, OP_DIV, 16'h55, 16'hAA, 16'h00, 0);
      check_run("div_by_zero", 16'h00, 16'h00, 1'b1, 5, 2);

      run(0, OP_DIV, 16'h10, 16'h00, 16'h10, 0);
      check_run("div_quot_ovf", 16'h00, 16'h00, 1'b1, 5, 2);

      run(0, OP_MUL, 16'hFD, 16'h05, 16'h00, 3);
      check_run("mul_begin_in_booth", 16'hFF, 16'hF1, 1'b0, 7, 2);

      // Abort a divide partway through its iterations with the async reset.
      @(posedge clk); #1;
      op_code = OP_DIV; inbus = 16'h01; beg8 = 1'b1;
      @(posedge clk); #1;
      beg8 = 1'b0; inbus = 16'h23;
      @(posedge clk); #1;
      inbus = 16'h10;
      repeat (5) @(posedge clk);
      #1;
      chk("busy_mid_div", 32'(busy8), 32'd1);
      reset = 1'b0;
      #2;
      chk("async_rst_outputs", {20'h0, valid8, end8, busy8, err8, outbus8}, 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;
      run(0, OP_DIV, 16'h01, 16'h23, 16'h10, 0);
      check_run("div_after_rst", 16'h12, 16'h03, 1'b0, 14, 2);

      run(1, OP_MUL, 16'h8000, 16'h8000, 16'h0000, 0);
      check_run("mul16_8000_8000", 16'h4000, 16'h0000, 1'b0, 11, 2);

      run(1, OP_DIV, 16'h0123, 16'h4567, 16'h1000, 0);
      check_run("div16_01234567_1000", 16'h1234, 16'h0567, 1'b0, 22, 2);

      for (int i = 0; i < 4; i++) begin
         a = 16'($urandom);
         b = 16'($urandom);
         pa = int'($signed(a));
         pb = int'($signed(b));
         prod = 32'(pa * pb);
         run(1, OP_MUL, a, b, 16'h0000, 0);
         check_run("rnd_mul16", prod[31:16], prod[15:0], 1'b0, 11, 2);
      end

      for (int i = 0; i < 4; i++) begin
         m   = 16'($urandom_range(1, 16'hFFFF));
         dh  = 16'($urandom % 32'(m));
         dl  = 16'($urandom);
         dvd = {dh, dl};
         run(1, OP_DIV, dh, dl, m, 0);
         check_run("rnd_div16", 16'(dvd / 32'(m)), 16'(dvd % 32'(m)), 1'b0, 22, 2);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
